// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : AHB-Lite encodings and refill FSM states for the I-cache.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int LINE_WORDS  = 4;
    localparam int OFFSET_BITS = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_BURST = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ERR   = 3'd4
    } refill_state_t;

endpackage
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl
// Description : I-cache miss sequencer; fetches one line with an AHB INCR4 read.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              refill_busy,
    output logic              refill_we,
    output logic [1:0]        refill_word_idx,
    output logic [DATA_W-1:0] refill_data,
    output logic [ADDR_W-1:0] refill_tag_addr,
    output logic              refill_done,
    output logic              refill_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HBURST,
    output logic [2:0]        HSIZE,
    output logic              HWRITE,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA
);

    localparam logic [1:0]        c_last_beat   = 2'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] c_offset_mask = ADDR_W'((1 << OFFSET_BITS) - 1);

    refill_state_t     r_state;
    logic [ADDR_W-1:0] r_base;
    logic [1:0]        r_addr_cnt;
    logic [1:0]        r_data_cnt;

    logic [ADDR_W-1:0] w_miss_base;
    logic [ADDR_W-1:0] w_next_haddr;

    assign w_miss_base  = miss_addr & ~c_offset_mask;
    // Aligned 16-byte line: the word offset is the only part that moves.
    assign w_next_haddr = {r_base[ADDR_W-1:OFFSET_BITS], r_addr_cnt + 2'd1, 2'b00};

    assign refill_tag_addr = r_base;
    assign HSIZE           = HSIZE_WORD;
    assign HWRITE          = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_base          <= '0;
            r_addr_cnt      <= '0;
            r_data_cnt      <= '0;
            HADDR           <= '0;
            HTRANS          <= HTRANS_IDLE;
            HBURST          <= HBURST_SINGLE;
            refill_busy     <= 1'b0;
            refill_we       <= 1'b0;
            refill_word_idx <= '0;
            refill_data     <= '0;
            refill_done     <= 1'b0;
            refill_err      <= 1'b0;
        end else begin
            refill_we   <= 1'b0;
            refill_done <= 1'b0;
            refill_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (miss_req) begin
                        r_state     <= ST_ADDR;
                        r_base      <= w_miss_base;
                        r_addr_cnt  <= '0;
                        r_data_cnt  <= '0;
                        HADDR       <= w_miss_base;
                        HTRANS      <= HTRANS_NONSEQ;
                        HBURST      <= HBURST_INCR4;
                        refill_busy <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        r_state    <= ST_BURST;
                        r_addr_cnt <= r_addr_cnt + 2'd1;
                        HADDR      <= w_next_haddr;
                        HTRANS     <= HTRANS_SEQ;
                    end
                end
                ST_BURST, ST_DRAIN: begin
                    if (refill_done) begin
                        r_state     <= ST_IDLE;
                        refill_busy <= 1'b0;
                    end else if (HRESP == HRESP_ERROR) begin
                        // Cancel the burst; the error pulse waits for the second error cycle.
                        r_state    <= ST_ERR;
                        HTRANS     <= HTRANS_IDLE;
                        HBURST     <= HBURST_SINGLE;
                        refill_err <= HREADY;
                    end else if (HREADY) begin
                        refill_we       <= 1'b1;
                        refill_word_idx <= r_data_cnt;
                        refill_data     <= HRDATA;
                        r_data_cnt      <= r_data_cnt + 2'd1;
                        if (r_data_cnt == c_last_beat) begin
                            refill_done <= 1'b1;
                        end
                        if (r_state == ST_BURST) begin
                            if (r_addr_cnt == c_last_beat) begin
                                r_state <= ST_DRAIN;
                                HTRANS  <= HTRANS_IDLE;
                                HBURST  <= HBURST_SINGLE;
                            end else begin
                                r_addr_cnt <= r_addr_cnt + 2'd1;
                                HADDR      <= w_next_haddr;
                            end
                        end
                    end
                end
                ST_ERR: begin
                    if (refill_err) begin
                        r_state     <= ST_IDLE;
                        refill_busy <= 1'b0;
                    end else if (HREADY) begin
                        refill_err <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    HTRANS      <= HTRANS_IDLE;
                    HBURST      <= HBURST_SINGLE;
                    refill_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_refill_ctrl
// Description : Random AHB slave plus line-level refill reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctrl;
    import icache_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              miss_req = 1'b0;
    logic [ADDR_W-1:0] miss_addr = '0;
    logic              refill_busy;
    logic              refill_we;
    logic [1:0]        refill_word_idx;
    logic [DATA_W-1:0] refill_data;
    logic [ADDR_W-1:0] refill_tag_addr;
    logic              refill_done;
    logic              refill_err;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic [2:0]        HBURST;
    logic [2:0]        HSIZE;
    logic              HWRITE;
    logic              HREADY = 1'b1;
    logic              HRESP = 1'b0;
    logic [DATA_W-1:0] HRDATA = '0;

    icache_refill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(4)) u_dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .refill_busy(refill_busy), .refill_we(refill_we), .refill_word_idx(refill_word_idx),
        .refill_data(refill_data), .refill_tag_addr(refill_tag_addr),
        .refill_done(refill_done), .refill_err(refill_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: line base, address phases done (a), beats accepted (d).
    bit          m_busy, m_cancel, m_finish;
    logic [31:0] m_base;
    int          m_a, m_d;
    bit          e_we, e_done, e_err;
    logic [1:0]  e_idx;
    logic [31:0] e_data;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_cancel = 0; m_finish = 0; m_base = '0; m_a = 0; m_d = 0;
        e_we = 0; e_done = 0; e_err = 0; e_idx = '0; e_data = '0;
    endtask

    task automatic model_step();
        bit data_out;
        e_we = 0; e_done = 0; e_err = 0;
        if (!m_busy) begin
            if (miss_req) begin
                m_busy = 1; m_base = miss_addr & 32'hFFFF_FFF0;
                m_a = 0; m_d = 0; m_cancel = 0; m_finish = 0;
            end
        end else if (m_finish) begin
            m_busy = 0; m_finish = 0;
        end else if (m_cancel) begin
            if (HREADY) begin e_err = 1; m_finish = 1; end
        end else begin
            data_out = (m_a > m_d);
            if (data_out && HRESP) begin
                m_cancel = 1;
                if (HREADY) begin e_err = 1; m_finish = 1; end
            end else if (HREADY) begin
                if (data_out) begin
                    e_we = 1; e_idx = 2'(m_d); e_data = HRDATA; m_d++;
                    if (m_d == 4) begin e_done = 1; m_finish = 1; end
                end
                if (m_a < 4) m_a++;
            end
        end
    endtask

    task automatic compare();
        bit active;
        active = m_busy && !m_cancel && (m_a < 4);
        chk_eq("HTRANS", HTRANS, active ? ((m_a == 0) ? HTRANS_NONSEQ : HTRANS_SEQ) : HTRANS_IDLE);
        chk_eq("HBURST", HBURST, active ? HBURST_INCR4 : HBURST_SINGLE);
        chk_eq("HSIZE", HSIZE, HSIZE_WORD);
        chk_eq("HWRITE", HWRITE, 1'b0);
        if (active) chk_eq("HADDR", HADDR, m_base + 32'(4 * m_a));
        chk_eq("refill_busy", refill_busy, m_busy);
        if (m_busy) chk_eq("refill_tag_addr", refill_tag_addr, m_base);
        chk_eq("refill_we", refill_we, e_we);
        if (e_we) begin
            chk_eq("refill_word_idx", refill_word_idx, e_idx);
            chk_eq("refill_data", refill_data, e_data);
        end
        chk_eq("refill_done", refill_done, e_done);
        chk_eq("refill_err", refill_err, e_err);
    endtask

    task automatic chk_reset(input string tag);
        chk_eq({tag, "_HTRANS"}, HTRANS, HTRANS_IDLE);
        chk_eq({tag, "_HADDR"}, HADDR, 32'h0);
        chk_eq({tag, "_HBURST"}, HBURST, HBURST_SINGLE);
        chk_eq({tag, "_HSIZE"}, HSIZE, HSIZE_WORD);
        chk_eq({tag, "_HWRITE"}, HWRITE, 1'b0);
        chk_eq({tag, "_busy"}, refill_busy, 1'b0);
        chk_eq({tag, "_we"}, refill_we, 1'b0);
        chk_eq({tag, "_idx"}, refill_word_idx, 2'd0);
        chk_eq({tag, "_data"}, refill_data, 32'h0);
        chk_eq({tag, "_tag"}, refill_tag_addr, 32'h0);
        chk_eq({tag, "_done"}, refill_done, 1'b0);
        chk_eq({tag, "_err"}, refill_err, 1'b0);
    endtask

    task automatic run_cycle();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic drive_random();
        miss_req  = ($urandom_range(0, 2) == 0);
        miss_addr = $urandom;
        HRDATA    = $urandom;
        if (m_busy && m_cancel && !m_finish) begin
            HRESP = 1'b1; HREADY = 1'b1;
        end else if (m_busy && !m_cancel && !m_finish && (m_a > m_d) && ($urandom_range(0, 24) == 0)) begin
            HRESP = 1'b1; HREADY = 1'b0;
        end else begin
            HRESP = 1'b0; HREADY = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic do_async_reset();
        #1 rst = 1'b1;
        #1 chk_reset("async_rst");
        model_reset();
        miss_req = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        run_cycle();
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 chk_reset("por");
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait line at 0x1040, then an unaligned miss issued in cycle 7.
        miss_req = 1'b1; miss_addr = 32'h0000_1040; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        for (int c = 1; c <= 8; c++) begin
            run_cycle();
            if (c <= 4) begin
                chk_eq("zw_haddr", HADDR, 32'h1040 + 32'(4 * (c - 1)));
                chk_eq("zw_htrans", HTRANS, (c == 1) ? HTRANS_NONSEQ : HTRANS_SEQ);
            end
            if (c <= 7) begin
                chk_eq("zw_busy", refill_busy, (c <= 6));
                chk_eq("zw_we", refill_we, (c >= 3 && c <= 6));
                chk_eq("zw_done", refill_done, (c == 6));
            end
            if (c >= 3 && c <= 6) chk_eq("zw_data", refill_data, 32'hA0 + 32'(c - 3));
            if (c == 8) begin
                chk_eq("unal_tag", refill_tag_addr, 32'h1000_0020);
                chk_eq("unal_haddr", HADDR, 32'h1000_0020);
                chk_eq("unal_htrans", HTRANS, HTRANS_NONSEQ);
            end
            miss_req  = (c == 7);
            miss_addr = 32'h1000_002C;
            HRDATA    = (c >= 2 && c <= 5) ? 32'hA0 + 32'(c - 2) : 32'h0;
        end

        for (int i = 0; i < 3000; i++) begin
            if (m_busy && ($urandom_range(0, 149) == 0)) do_async_reset();
            drive_random();
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Miss/refill sequencer for the AHB I-cache.
- When the cache lookup misses on a CPU fetch, this block issues one aligned INCR4 AHB-Lite read burst for the missing line.
- It streams the returned words into the cache data/tag arrays and signals completion or bus error back to the cache front end.
- It is the only AHB master in the cache subsystem.

Parameters:
- ADDR_W, 32, byte-address width of the CPU request and HADDR.
- DATA_W, 32, word width of HRDATA and refill_data.
- LINE_WORDS, 4, words per cache line; fixed to 4 to match INCR4; other values are illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- miss_req  in  1  lookup missed; sampled only in IDLE.
- miss_addr  in  ADDR_W  fetch address that missed; offset bits ignored.
- refill_busy  out  1  high from first address phase until the cycle of refill_done/refill_err inclusive.
- refill_we  out  1  write strobe, one word, into the line buffer/data array.
- refill_word_idx  out  2  word index within line for refill_we.
- refill_data  out  DATA_W  word to write.
- refill_tag_addr  out  ADDR_W  line base address (miss_addr with low 4 bits cleared), held while busy.
- refill_done  out  1  one-cycle pulse: full line written, mark line valid.
- refill_err  out  1  one-cycle pulse: bus error, line must not be validated.
- HADDR  out  ADDR_W  AHB address.
- HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11.
- HBURST  out  3  INCR4=011 during burst, SINGLE=000 otherwise.
- HSIZE  out  3  word=010.
- HWRITE  out  1  constant 0.
- HREADY  in  1  slave ready.
- HRESP  in  1  0=OKAY, 1=ERROR.
- HRDATA  in  DATA_W  read data.

Behaviour:
- Reset values: HTRANS=IDLE, HADDR=0, HBURST=000, HSIZE=010, HWRITE=0. All refill_* outputs are 0. The FSM is in IDLE.
- Reset is asynchronous and takes effect mid-burst. Partial line data is abandoned. No done or err pulse is produced.
- States: IDLE, ADDR, BURST, DRAIN, ERR.
- IDLE:
  - miss_req=1 at an edge → ADDR.
  - On that same edge, latch base = miss_addr & ~0xF.
  - Drive HTRANS=NONSEQ, HADDR=base, HBURST=INCR4. refill_busy=1.
- ADDR / BURST (address counter a=0..3):
  - An address phase completes on an edge with HREADY=1.
  - On completion, a increments and the next cycle drives SEQ with HADDR=base+4*a.
  - With HREADY=0, HADDR/HTRANS/HBURST hold unchanged.
  - After beat 3's address completes, → DRAIN with HTRANS=IDLE, HBURST=000.
- Data phase (counter d=0..3): a beat is accepted on an edge with HREADY=1 and HRESP=0 while a data phase is outstanding.
- Write-back of accepted beats:
  - The next cycle has refill_we=1, refill_word_idx=d, refill_data=registered HRDATA.
  - On the 4th beat, refill_done=1 in that same cycle, then → IDLE.
  - Zero-wait latency: miss_req sampled at edge E0; NONSEQ in cycle 1; beats accepted at the ends of cycles 2–5; refill_we in cycles 3–6; refill_done in cycle 6; refill_busy in cycles 1–6; a new miss_req is accepted at the end of cycle 7.
- ERROR response:
  - HRESP=1 with HREADY=0 (first error cycle) → drive HTRANS=IDLE in the next cycle (burst cancelled), enter ERR.
  - On the second error cycle (HRESP=1, HREADY=1), pulse refill_err for one cycle with no refill_we, then → IDLE.
  - Words already written stay written, but the line is never validated.
- miss_req while busy is ignored; the front end must hold it or re-issue it.
- The burst is 16-byte aligned and never crosses a 1 KB boundary. No BUSY transfers are ever issued.
- refill_done and refill_err are mutually exclusive and each lasts exactly one cycle.

Decomposition:
- Shared package icache_pkg:
  - HTRANS_IDLE/NONSEQ/SEQ, HBURST_SINGLE/INCR4, HSIZE_WORD, HRESP_OKAY/ERROR constants.
  - LINE_WORDS, OFFSET_BITS=4.
  - The refill_state_t enum.
- No sub-module: a single FSM plus two 2-bit counters and a data register.

Test Plan:
- Zero-wait refill:
  - Stimulus: miss_addr=0x0000_1040 with the slave returning 0xA0..0xA3.
  - Required: HADDR sequence 0x1040/44/48/4C with NONSEQ,SEQ,SEQ,SEQ; refill_we idx 0..3 carrying 0xA0..0xA3; refill_done in cycle 6; busy cycles 1–6.
- Unaligned miss:
  - Stimulus: miss_addr=0x1000_002C.
  - Required: refill_tag_addr=0x1000_0020 and the burst starts at 0x1000_0020.
- Wait states:
  - Stimulus: HREADY=0 for 2 cycles during beat 1's data phase.
  - Required: HADDR holds 0x…48 with SEQ; refill_we for idx1 is delayed 2 cycles; done is 2 cycles later than in the zero-wait case.
- Bus error:
  - Stimulus: two-cycle ERROR on beat 2.
  - Required: HTRANS=IDLE in the 2nd error cycle; refill_err pulses once; refill_we only for idx0,1; no refill_done.
- Busy request:
  - Stimulus: miss_req re-pulsed to 0x2000 mid-burst.
  - Required: ignored, HADDR stays in the 0x1040 line; a fresh miss_req after done starts a new burst at 0x2000.
- Reset mid-burst:
  - Stimulus: rst asserted asynchronously during beat 2.
  - Required: all outputs return to reset values immediately; no done/err pulse; a later miss completes normally.
